// File: rtl/aclk_controller.sv
// Alarm clock keypad/button sequencer: turns digit keys and ALARM/TIME buttons
// into key-buffer shift strobes, display selects and one-cycle load pulses.
module aclk_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       show_new_time,
  output logic       show_a,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic [2:0] digit_cnt
);

  // state            | meaning
  // SHOW_TIME        | idle, display shows current time
  // KEY_STORED       | one cycle, key buffer shifts in the digit
  // KEY_WAITED       | waiting for the held key to be released
  // KEY_ENTRY        | key released, waiting for next digit or a button
  // SHOW_ALARM       | ALARM held in idle, display shows alarm time
  // SET_ALARM_TIME   | one cycle, alarm register loads the key buffer
  // SET_CURRENT_TIME | one cycle, time counter loads the key buffer

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;

  localparam logic [3:0] NOKEY    = 4'd10;
  localparam logic [3:0] TMO_LAST = 4'd9;
  localparam logic [2:0] DIGITS   = 3'd4;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] tmo_cnt;
  logic       digit_vld;
  logic       no_key;
  logic       timeout;
  logic       cnt_full;

  assign digit_vld = (key < NOKEY);
  assign no_key    = (key >= NOKEY);
  assign timeout   = (tmo_cnt == TMO_LAST) && one_second;
  assign cnt_full  = (digit_cnt == DIGITS);

  always_comb begin
    state_nxt = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)   state_nxt = SHOW_ALARM;
        else if (digit_vld) state_nxt = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_nxt = SHOW_TIME;
      end
      KEY_STORED: state_nxt = KEY_WAITED;
      KEY_WAITED: begin
        if (no_key)       state_nxt = KEY_ENTRY;
        else if (timeout) state_nxt = SHOW_TIME;
      end
      KEY_ENTRY: begin
        // buttons beat digits, digits beat the timeout tick
        if (alarm_button)     state_nxt = cnt_full ? SET_ALARM_TIME : SHOW_TIME;
        else if (time_button) state_nxt = cnt_full ? SET_CURRENT_TIME : SHOW_TIME;
        else if (digit_vld)   state_nxt = KEY_STORED;
        else if (timeout)     state_nxt = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_nxt = SHOW_TIME;
      SET_CURRENT_TIME: state_nxt = SHOW_TIME;
      default:          state_nxt = SHOW_TIME;
    endcase
  end

  // Outputs are registered from the next state so they equal a decode of state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= SHOW_TIME;
      tmo_cnt       <= 4'd0;
      digit_cnt     <= 3'd0;
      shift         <= 1'b0;
      show_new_time <= 1'b0;
      show_a        <= 1'b0;
      load_new_c    <= 1'b0;
      load_new_a    <= 1'b0;
    end else begin
      state         <= state_nxt;
      shift         <= (state_nxt == KEY_STORED);
      show_new_time <= (state_nxt == KEY_STORED) || (state_nxt == KEY_WAITED) ||
                       (state_nxt == KEY_ENTRY);
      show_a        <= (state_nxt == SHOW_ALARM);
      load_new_a    <= (state_nxt == SET_ALARM_TIME);
      load_new_c    <= (state_nxt == SET_CURRENT_TIME);

      if (state == SHOW_TIME)
        digit_cnt <= 3'd0;
      else if ((state == KEY_STORED) && !cnt_full)
        digit_cnt <= digit_cnt + 3'd1;

      if ((state == SHOW_TIME) || (state == KEY_STORED))
        tmo_cnt <= 4'd0;
      else if (((state == KEY_WAITED) || (state == KEY_ENTRY)) && one_second &&
               (tmo_cnt != TMO_LAST))
        tmo_cnt <= tmo_cnt + 4'd1;
    end
  end

endmodule
